// File: rtl/ff_calc_pkg.sv
// rtl/ff_calc_pkg.sv - key codes, token values and feeder state shared by the calculator blocks
package ff_calc_pkg;

  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [31:0] TOKEN_FUNC = 32'h8000_0000;
  localparam logic [31:0] TOKEN_ADD  = 32'h8000_000A;
  localparam logic [31:0] TOKEN_SUB  = 32'h8000_000B;
  localparam logic [31:0] TOKEN_MUL  = 32'h8000_000C;
  localparam logic [31:0] TOKEN_DIV  = 32'h8000_000D;
  localparam logic [31:0] TOKEN_EQ   = 32'h8000_000E;
  localparam logic [31:0] TOKEN_CLR  = 32'h8000_000F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_NUM,
    ST_SEND_OP,
    ST_HOLD_NUM,
    ST_HOLD_OP
  } feeder_state_t;

  // Function tokens carry the key code in the low nibble with bit 31 set.
  function automatic logic [31:0] op_token(input logic [3:0] code);
    return TOKEN_FUNC | {28'd0, code};
  endfunction

endpackage

// File: rtl/decimal_accum.sv
// rtl/decimal_accum.sv - decimal operand accumulator with digit count and sticky overflow
module decimal_accum #(
  parameter int MAX_DIGITS = 9,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [3:0]    digit,
  input  logic          clear_num,
  input  logic          clear_all,
  output logic [31:0]   value,
  output logic [CW-1:0] count,
  output logic          overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_all) begin
      value    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_num) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      if (count == CW'(MAX_DIGITS)) begin
        overflow <= 1'b1;
      end else begin
        // value*10 + digit without a multiplier
        value <= (value << 3) + (value << 1) + {28'd0, digit};
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_token_feeder.sv
// rtl/ff_token_feeder.sv - turns keypad codes into the calculator's number/function token stream
// Optional FF_FEEDER_AUTO_CLR_EN: emit a clear token before the first token of each expression.
module ff_token_feeder
  import ff_calc_pkg::*;
#(
  parameter int MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key,
  output logic        key_ready,
  input  logic        calc_ready,
  output logic        strobe,
  output logic [31:0] token,
  output logic        overflow
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  feeder_state_t state;
  logic [3:0]    op;
  logic [31:0]   acc_value;
  logic [CW-1:0] acc_count;

  logic          key_fire;
  logic          in_valid;
  logic [3:0]    in_key;
  logic          in_is_digit;
  logic          divert;
  logic          idle_take;

  assign key_fire    = key_valid & key_ready;
  assign in_is_digit = (in_key <= KEY_9);
  assign idle_take   = (state == ST_IDLE) && in_valid && !divert;
  assign strobe      = ((state == ST_SEND_NUM) || (state == ST_SEND_OP)) && calc_ready;

`ifdef FF_FEEDER_AUTO_CLR_EN
  logic       new_expr;
  logic       pend_valid;
  logic [3:0] pend_key;

  // The key that opens an expression is parked while the clear goes out.
  assign key_ready = (state == ST_IDLE) && !pend_valid;
  assign in_valid  = pend_valid | key_fire;
  assign in_key    = pend_valid ? pend_key : key;
  assign divert    = key_fire && new_expr && (key != KEY_CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_expr   <= 1'b1;
      pend_valid <= 1'b0;
      pend_key   <= '0;
    end else begin
      if (divert) begin
        new_expr   <= 1'b0;
        pend_valid <= 1'b1;
        pend_key   <= key;
      end else if (idle_take) begin
        pend_valid <= 1'b0;
        if (in_key == KEY_CLR) new_expr <= 1'b0;
      end
      if ((state == ST_SEND_OP) && calc_ready && (op == KEY_EQ)) new_expr <= 1'b1;
    end
  end
`else
  assign key_ready = (state == ST_IDLE);
  assign in_valid  = key_fire;
  assign in_key    = key;
  assign divert    = 1'b0;
`endif

  decimal_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .CW         (CW)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .load      (idle_take && in_is_digit),
    .digit     (in_key),
    .clear_num ((state == ST_SEND_NUM) && calc_ready),
    .clear_all (idle_take && (in_key == KEY_CLR)),
    .value     (acc_value),
    .count     (acc_count),
    .overflow  (overflow)
  );

  // token is loaded on entry to a SEND state so it is valid with the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= '0;
      token <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (divert) begin
            op    <= KEY_CLR;
            token <= TOKEN_CLR;
            state <= ST_SEND_OP;
          end else if (idle_take && !in_is_digit) begin
            op <= in_key;
            if ((in_key != KEY_CLR) && (acc_count != '0)) begin
              token <= acc_value;
              state <= ST_SEND_NUM;
            end else begin
              token <= op_token(in_key);
              state <= ST_SEND_OP;
            end
          end
        end
        ST_SEND_NUM: if (calc_ready) state <= ST_HOLD_NUM;
        ST_HOLD_NUM: begin
          token <= op_token(op);
          state <= ST_SEND_OP;
        end
        ST_SEND_OP:  if (calc_ready) state <= ST_HOLD_OP;
        ST_HOLD_OP:  state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ff_token_feeder.md
# ff_token_feeder

Keypad-side token producer for the four-function calculator: accepts 4-bit key codes (0–9 digits, A–F functions), assembles multi-digit decimal operands into 32-bit number tokens, and drives the calculator's strobe/token/ready input port one token at a time. Sits between the keypad debouncer/scanner and the calculator core, converting keystrokes into the calculator's infix token stream.

## Interface
- `MAX_DIGITS`, 9: decimal digits accepted per operand; 9 keeps every operand below 2^31.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  key code present on `key`.
- `key`  in  4  0–9 digit; A `+`, B `-`, C `*`, D `/`, E `=`, F clear.
- `key_ready`  out  1  feeder accepts a key this cycle; a key transfers when `key_valid & key_ready`.
- `calc_ready`  in  1  calculator ready for the next token.
- `strobe`  out  1  single-cycle token write to the calculator.
- `token`  out  32  token value; number tokens are 0–999,999,999, function tokens are 32'h8000000A–32'h8000000F (key code in bits 3:0, bit 31 set).
- `overflow`  out  1  sticky: a digit beyond `MAX_DIGITS` was dropped.

## Operation
- States: IDLE, SEND_NUM, SEND_OP, HOLD_NUM, HOLD_OP.
- IDLE, `key_ready`=1:
  - Digit: value <= value*10 + digit, computed as (v<<3)+(v<<1)+d; digit count +1; stay IDLE.
    - If count is already `MAX_DIGITS`, the digit is dropped and `overflow` is set.
  - Operator A–E: latch op code. Go to SEND_NUM if a digit is pending, else SEND_OP.
  - Clear F: discard value, count, and `overflow`; latch op F; go to SEND_OP. No number token is sent.
- SEND_NUM: wait for `calc_ready`. Then pulse `strobe` with `token`=value, clear value and count, go to HOLD_NUM.
- HOLD_NUM: one gap cycle, `strobe`=0; go to SEND_OP.
- SEND_OP: wait for `calc_ready`. Then pulse `strobe` with `token`=32'h80000000|op, go to HOLD_OP.
- HOLD_OP: one gap cycle; go to IDLE.
- `key_ready` is 0 in every state except IDLE.
- `token` holds its last value while `strobe`=0.
- Operator with no pending digits (e.g. `=` right after `+`) sends only the function token; the calculator handles the semantics.
- Reset mid-emission: FSM returns to IDLE immediately; any partially sent sequence is abandoned; no strobe is issued.

## Timing
- Reset values: `key_ready`=1, `strobe`=0, `token`=0, `overflow`=0; internal value and count 0; FSM in IDLE.
- Digits are accepted back-to-back, one per cycle.
- Operator accepted at edge k with `calc_ready` held high:
  - Number strobe in cycle k+1.
  - Gap in cycle k+2.
  - Operator strobe in cycle k+3.
  - Gap in cycle k+4.
  - `key_ready`=1 in cycle k+5.
- Each wait for `calc_ready` adds cycles 1:1 to this latency.
- `strobe` is never high in two consecutive cycles.
- `strobe` is only asserted in a cycle where `calc_ready`=1.
- `token` is registered and is valid in the same cycle as `strobe`.

## Configuration
- `FF_FEEDER_AUTO_CLR_EN` defined:
  - A clear token (32'h8000000F) is inserted automatically before the first token of a new expression.
  - A new expression starts at the first key after reset or after an `=` has been sent.
  - The inserted clear uses the SEND_OP/HOLD_OP path; the triggering key is then processed normally (a digit is accumulated; an operator proceeds to SEND_NUM/SEND_OP).
  - An explicit F key in this condition sends exactly one clear, not two.
- Undefined: no automatic tokens. The user must press F before each calculation.

## Structure
- Shared package `ff_calc_pkg` holds:
  - the token constants TOKEN_ADD..TOKEN_CLR (32'h8000000A–F);
  - the key-code constants;
  - the feeder state enum.
- The calculator core uses the same token constants from `ff_calc_pkg`.
- Sub-module `decimal_accum`: holds value and digit count, with load-digit, clear, and `overflow` outputs. The feeder FSM instantiates it once.

## Test plan
- Keys 1,2,3,A,4,5,E with `calc_ready`=1 → strobes in order: 32'd123, 32'h8000000A, 32'd45, 32'h8000000E. No two strobes are adjacent.
- Ten digit keys 9 → token 32'd999999999 and `overflow`=1. After an F key: clear token sent and `overflow`=0.
- Key 7 then C with `calc_ready` held low 5 cycles → `strobe` stays 0 and `key_ready`=0 throughout; 32'd7 is sent in the first cycle `calc_ready` returns high.
- Keys 5, F → only 32'h8000000F is sent; the next operand starts from 0.
- `rst` asserted in SEND_OP → `strobe` drops immediately, `key_ready`=1, and no further strobe occurs until new keys arrive.
- With `FF_FEEDER_AUTO_CLR_EN` defined: after reset, keys 2,E → strobes 32'h8000000F, 32'd2, 32'h8000000E. The next key 3 triggers another 32'h8000000F before the number.
